// File: rtl/tick_period_meter_if.sv
// Tick-period meter port bundle: tick stimulus in, measured period and lock/status out.
// The master side drives the tick stream; the slave side is the meter itself.
interface tick_period_meter_if #(
    parameter int WIDTH = 28
);
    logic             enable;
    logic             tick_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;
    logic [7:0]       err_count;

    modport master (
        output enable, tick_in,
        input  period, period_valid, locked, timeout, err_count
    );

    modport slave (
        input  enable, tick_in,
        output period, period_valid, locked, timeout, err_count
    );
endinterface

// File: rtl/tick_period_meter.sv
// Measures the clk-cycle distance between consecutive single-cycle ticks and tracks
// lock against an expected period, with sticky timeout and a saturating error count.
module tick_period_meter #(
    parameter int WIDTH      = 28,
    parameter int EXPECTED   = 833334,
    parameter int TOL        = 16,
    parameter int LOCK_COUNT = 4
) (
    input logic               clk,
    input logic               reset,
    tick_period_meter_if.slave bus
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam int               TOL_LO_INT = (EXPECTED > TOL) ? EXPECTED - TOL : 0;
    localparam logic [WIDTH:0]   TOL_LO     = (WIDTH+1)'(TOL_LO_INT);
    localparam logic [WIDTH:0]   TOL_HI     = (WIDTH+1)'(EXPECTED + TOL);
    localparam logic [3:0]       LOCK_N     = 4'(LOCK_COUNT);

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] period_q, period_next;
    logic             valid_q, valid_next;
    logic             locked_q, locked_next;
    logic             timeout_q, timeout_next;
    logic [7:0]       err_q, err_next;
    logic [3:0]       run, run_next;

    logic [WIDTH:0]   meas;
    logic [WIDTH-1:0] meas_sat;
    logic             in_tol;

    // Edge-to-edge distance is the count of enabled idle cycles plus the tick cycle itself.
    assign meas     = {1'b0, cnt} + (WIDTH+1)'(1);
    assign meas_sat = meas[WIDTH] ? CNT_MAX : meas[WIDTH-1:0];
    assign in_tol   = ({1'b0, meas_sat} >= TOL_LO) && ({1'b0, meas_sat} <= TOL_HI);

    // NOTE: every variable gets its hold value before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        period_next  = period_q;
        valid_next   = 1'b0;
        locked_next  = locked_q;
        timeout_next = timeout_q;
        err_next     = err_q;
        run_next     = run;

        if (bus.enable) begin
            unique case (state)
                IDLE: begin
                    if (bus.tick_in) begin
                        cnt_next   = '0;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (bus.tick_in) begin
                        period_next = meas_sat;
                        valid_next  = 1'b1;
                        cnt_next    = '0;
                        if (in_tol) begin
                            run_next = (run >= LOCK_N) ? LOCK_N : run + 4'd1;
                            if ({1'b0, run} + 5'd1 >= {1'b0, LOCK_N})
                                locked_next = 1'b1;
                        end else begin
                            run_next    = '0;
                            locked_next = 1'b0;
                            if (err_q != 8'hFF)
                                err_next = err_q + 8'd1;
                        end
                    end else if (cnt == CNT_MAX) begin
                        // Lost the tick stream: drop lock and wait for a fresh first tick.
                        timeout_next = 1'b1;
                        locked_next  = 1'b0;
                        run_next     = '0;
                        state_next   = IDLE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            run       <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            period_q  <= period_next;
            valid_q   <= valid_next;
            locked_q  <= locked_next;
            timeout_q <= timeout_next;
            err_q     <= err_next;
            run       <= run_next;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;
    assign bus.err_count    = err_q;
endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter (WIDTH=8, EXPECTED=10, TOL=1, LOCK_COUNT=3):
// stimulus pushes hand-computed reports; a monitor pops them on each period_valid.
module tb_tick_period_meter;
    typedef struct {
        logic [7:0] period;
        logic       locked;
        logic       timeout;
        logic [7:0] err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    tick_period_meter_if #(.WIDTH(8)) bus ();

    tick_period_meter #(
        .WIDTH(8), .EXPECTED(10), .TOL(1), .LOCK_COUNT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One clock cycle of stimulus, sampled by the DUT at the coming posedge.
    task automatic cycle(input logic t, input logic en);
        bus.tick_in = t;
        bus.enable  = en;
        @(posedge clk);
        #1;
        bus.tick_in = 1'b0;
        bus.enable  = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b1);
    endtask

    task automatic expect_report(input logic [7:0] p, input logic lk, input logic to, input logic [7:0] ec);
        exp_t e;
        e.period  = p;
        e.locked  = lk;
        e.timeout = to;
        e.err     = ec;
        exp_q.push_back(e);
    endtask

    // Tick n cycles after the previous one, expecting the given report.
    task automatic gap_tick(input int n, input logic [7:0] p, input logic lk, input logic to, input logic [7:0] ec);
        idle(n - 1);
        expect_report(p, lk, to, ec);
        cycle(1'b1, 1'b1);
    endtask

    // Monitor: every period_valid must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.period_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("period",    32'(bus.period),    32'(e.period));
                    check("locked",    32'(bus.locked),    32'(e.locked));
                    check("timeout",   32'(bus.timeout),   32'(e.timeout));
                    check("err_count", 32'(bus.err_count), 32'(e.err));
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.tick_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        check("rst_period",  32'(bus.period),       32'd0);
        check("rst_valid",   32'(bus.period_valid), 32'd0);
        check("rst_locked",  32'(bus.locked),       32'd0);
        check("rst_timeout", 32'(bus.timeout),      32'd0);
        check("rst_err",     32'(bus.err_count),    32'd0);

        // Lock acquisition: first tick silent, lock on the third in-tolerance period.
        cycle(1'b1, 1'b1);
        gap_tick(10, 8'd10, 1'b0, 1'b0, 8'd0);
        gap_tick(10, 8'd10, 1'b0, 1'b0, 8'd0);
        gap_tick(10, 8'd10, 1'b1, 1'b0, 8'd0);

        // One late tick breaks lock; 9/11/10 are all inside +-1 and relock.
        gap_tick(13, 8'd13, 1'b0, 1'b0, 8'd1);
        gap_tick(9,  8'd9,  1'b0, 1'b0, 8'd1);
        gap_tick(11, 8'd11, 1'b0, 1'b0, 8'd1);
        gap_tick(10, 8'd10, 1'b1, 1'b0, 8'd1);

        // Starvation: cnt reaches 255 after 255 idle cycles, timeout on the 256th.
        idle(255);
        check("timeout_early", 32'(bus.timeout), 32'd0);
        check("locked_early",  32'(bus.locked),  32'd1);
        idle(1);
        check("timeout_set",   32'(bus.timeout), 32'd1);
        check("locked_drop",   32'(bus.locked),  32'd0);
        idle(44);

        // Restart from IDLE: first tick silent, timeout stays sticky.
        cycle(1'b1, 1'b1);
        gap_tick(10, 8'd10, 1'b0, 1'b1, 8'd1);
        gap_tick(10, 8'd10, 1'b0, 1'b1, 8'd1);

        // 15 raw cycles with 5 disabled (one carrying a tick) measure as 10.
        idle(4);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        idle(5);
        expect_report(8'd10, 1'b1, 1'b1, 8'd1);
        cycle(1'b1, 1'b1);

        // Async reset mid-period while locked clears everything before the next edge.
        idle(4);
        check("pre_rst_locked", 32'(bus.locked), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_period",  32'(bus.period),       32'd0);
        check("arst_valid",   32'(bus.period_valid), 32'd0);
        check("arst_locked",  32'(bus.locked),       32'd0);
        check("arst_timeout", 32'(bus.timeout),      32'd0);
        check("arst_err",     32'(bus.err_count),    32'd0);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // First tick after reset is silent; held tick then gives period 1 per cycle.
        cycle(1'b1, 1'b1);
        expect_report(8'd1, 1'b0, 1'b0, 8'd1);
        cycle(1'b1, 1'b1);
        expect_report(8'd1, 1'b0, 1'b0, 8'd2);
        cycle(1'b1, 1'b1);
        expect_report(8'd1, 1'b0, 1'b0, 8'd3);
        cycle(1'b1, 1'b1);
        idle(5);

        check("reports_outstanding", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Receive-side companion to the rate-divider tick generators.
- Consumes a single-cycle tick pulse stream and measures the clk-cycle period between consecutive ticks.
- Reports each measured period with a one-cycle valid strobe.
- Maintains a lock flag against an expected period, plus sticky timeout/error status; used to check the 60 Hz tick path in-system.

Parameters:
- WIDTH, 28, width of the period counter and period output.
- EXPECTED, 833334, nominal tick period in clk cycles (divider reload value + 1).
- TOL, 16, allowed absolute deviation from EXPECTED, inclusive.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  measurement enable; low freezes all state.
- tick_in  input  1  single-cycle tick pulse under test.
- period  output  WIDTH  last measured period in clk cycles.
- period_valid  output  1  one-cycle strobe when period updates.
- locked  output  1  EXPECTED±TOL met LOCK_COUNT times in a row.
- timeout  output  1  sticky: counter saturated with no tick.
- err_count  output  8  saturating count of out-of-tolerance periods.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, period=0, period_valid=0, locked=0, timeout=0, err_count=0, run=0.
- enable=0: cnt, state, run and all outputs hold; tick_in ignored; period_valid forced 0 that cycle.
- All rules below apply only with enable=1.
- States: IDLE, MEASURE.
- IDLE:
  - tick_in=1 -> cnt<=0, go MEASURE.
  - No period is reported for the first tick.
- MEASURE, tick_in=0:
  - cnt<=cnt+1, saturating at all-ones.
  - If cnt is already all-ones on a non-tick cycle: timeout<=1, locked<=0, run<=0, go IDLE.
- MEASURE, tick_in=1:
  - period<=cnt+1 (edge-to-edge distance; ticks at cycles t0,t1 give t1-t0).
  - period_valid<=1 next cycle only; cnt<=0; stay MEASURE.
- Tolerance check on each reported period P:
  - in = (P >= EXPECTED-TOL) and (P <= EXPECTED+TOL), computed at WIDTH+1 bits, no wrap.
  - in: run<=run+1, saturating at LOCK_COUNT; locked<=1 when run+1 >= LOCK_COUNT.
  - not in: run<=0, locked<=0, err_count<=err_count+1, saturating at 255.
- Back-to-back ticks (consecutive cycles) are legal: period=1, tolerance-checked normally.
- timeout is sticky until reset. Subsequent ticks restart measurement from IDLE; period and err_count keep prior values.
- Latency: period, period_valid, locked and err_count all update on the clk edge after the sampled tick.
- tick_in held high for N cycles is treated as N ticks (period=1 each); upstream guarantees single-cycle pulses.

Test Plan:
- WIDTH=8, EXPECTED=10, TOL=1, LOCK_COUNT=3; reset, then ticks every 10 cycles x4 -> first tick gives no valid; 3 valids with period=10; locked rises with the 3rd valid; err_count=0.
- Same config, locked; one tick 13 cycles after the previous -> period=13 valid, locked=0, err_count=1; next 3 periods of 9/11/10 -> locked=1 again.
- WIDTH=8; one tick then no ticks for 300 cycles -> timeout=1 after cnt saturates at 255; state IDLE; next two ticks 10 apart -> period=10, timeout still 1.
- enable low for 5 cycles mid-period (tick spacing 15 raw cycles) -> period=10; tick during enable=0 ignored.
- Assert reset mid-period while locked -> all outputs 0 immediately (async); following tick treated as first tick (no valid).
- Ticks on consecutive cycles -> period=1, period_valid each cycle, err_count increments per tick.
